// File: rtl/fifo_stream_bridge_6502.sv
// fifo_stream_bridge_6502
// Memory-mapped bridge between a 6502-style CPU bus and two byte streams.
// CPU writes to TxData are queued in a TX FIFO and drained by a stream
// consumer. A stream producer fills an RX FIFO that the CPU pops through RxData.
// Register map relative to BaseAddress:
//   +0 TxData  (W) push into TX FIFO
//   +1 RxData  (R) pop RX head
//   +2 Status  (R) {rx_underflow, tx_overflow, rx_empty, rx_full, tx_empty, tx_full}
//   +3 Control (W) bit0 clear sticky, bit1 flush TX, bit2 flush RX; (R) RX occupancy
module fifo_stream_bridge_6502 #(
  parameter int BaseAddress   = 0,
  parameter int FIFOSize      = 4,
  parameter int address_width = 16,
  parameter int data_width    = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [address_width-1:0] address_i,
  input  logic [data_width-1:0]    data_i,
  output logic [data_width-1:0]    data_o,
  input  logic                     rd_wr_i,
  output logic [data_width-1:0]    tx_data_o,
  output logic                     tx_valid_o,
  input  logic                     tx_ready_i,
  input  logic [data_width-1:0]    rx_data_i,
  input  logic                     rx_valid_i,
  output logic                     rx_ready_o
);

  localparam int depth_n = 1 << FIFOSize;

  // Occupancy counters are one bit wider than the pointers so "full" is representable.
  localparam logic [FIFOSize:0]   cnt_depth_c = (FIFOSize + 1)'(depth_n);
  localparam logic [FIFOSize:0]   cnt_one_c   = (FIFOSize + 1)'(1);
  localparam logic [FIFOSize:0]   cnt_zero_c  = {(FIFOSize + 1){1'b0}};
  localparam logic [FIFOSize-1:0] ptr_one_c   = (FIFOSize)'(1);
  localparam logic [FIFOSize-1:0] ptr_zero_c  = {FIFOSize{1'b0}};
  localparam logic [data_width-1:0] data_zero_c = {data_width{1'b0}};

  localparam logic [address_width-1:0] addr_tx_c     = address_width'(BaseAddress);
  localparam logic [address_width-1:0] addr_rx_c     = address_width'(BaseAddress + 1);
  localparam logic [address_width-1:0] addr_status_c = address_width'(BaseAddress + 2);
  localparam logic [address_width-1:0] addr_ctrl_c   = address_width'(BaseAddress + 3);

  // Storage (no reset needed, validity is tracked by pointers and counts)
  logic [data_width-1:0] tx_mem [depth_n];
  logic [data_width-1:0] rx_mem [depth_n];

  // FIFO bookkeeping registers
  logic [FIFOSize-1:0] tx_wr_ptr_r;
  logic [FIFOSize-1:0] tx_rd_ptr_r;
  logic [FIFOSize:0]   tx_count_r;
  logic [FIFOSize-1:0] rx_wr_ptr_r;
  logic [FIFOSize-1:0] rx_rd_ptr_r;
  logic [FIFOSize:0]   rx_count_r;

  // Sticky error flags and registered read data
  logic                  tx_overflow_r;
  logic                  rx_underflow_r;
  logic [data_width-1:0] data_r;

  // Decoded bus accesses
  logic tx_wr_s;
  logic ctrl_wr_s;
  logic rx_rd_s;
  logic status_rd_s;
  logic ctrl_rd_s;

  // FIFO status derived from pre-edge state
  logic tx_full_s;
  logic tx_empty_s;
  logic rx_full_s;
  logic rx_empty_s;

  // Per-edge actions
  logic tx_push_s;
  logic tx_pop_s;
  logic tx_overflow_set_s;
  logic tx_flush_s;
  logic rx_push_s;
  logic rx_pop_s;
  logic rx_underflow_set_s;
  logic rx_flush_s;
  logic flag_clear_s;

  logic [FIFOSize:0]     tx_count_next_s;
  logic [FIFOSize:0]     rx_count_next_s;
  logic [5:0]            status_s;
  logic [data_width-1:0] rd_data_s;

  assign tx_full_s  = (tx_count_r == cnt_depth_c);
  assign tx_empty_s = (tx_count_r == cnt_zero_c);
  assign rx_full_s  = (rx_count_r == cnt_depth_c);
  assign rx_empty_s = (rx_count_r == cnt_zero_c);

  // Stream handshake levels are forced low while reset is held.
  assign tx_valid_o = !reset_i && !tx_empty_s;
  assign rx_ready_o = !reset_i && !rx_full_s;
  assign tx_data_o  = tx_mem[tx_rd_ptr_r];
  assign data_o     = data_r;

  assign status_s = {rx_underflow_r, tx_overflow_r, rx_empty_s, rx_full_s, tx_empty_s, tx_full_s};

  // Decode the bus: the direction selects which registers can respond.
  always_comb begin
    tx_wr_s     = 1'b0;
    ctrl_wr_s   = 1'b0;
    rx_rd_s     = 1'b0;
    status_rd_s = 1'b0;
    ctrl_rd_s   = 1'b0;
    if (rd_wr_i) begin
      tx_wr_s   = (address_i == addr_tx_c);
      ctrl_wr_s = (address_i == addr_ctrl_c);
    end else begin
      rx_rd_s     = (address_i == addr_rx_c);
      status_rd_s = (address_i == addr_status_c);
      ctrl_rd_s   = (address_i == addr_ctrl_c);
    end
  end

  // Derive push/pop/flag actions; full/empty always reflect the pre-edge state.
  always_comb begin
    tx_flush_s         = ctrl_wr_s && data_i[1];
    rx_flush_s         = ctrl_wr_s && data_i[2];
    flag_clear_s       = ctrl_wr_s && data_i[0];
    tx_push_s          = tx_wr_s && !tx_full_s;
    tx_overflow_set_s  = tx_wr_s && tx_full_s;
    tx_pop_s           = !tx_empty_s && tx_ready_i;
    rx_push_s          = rx_valid_i && !rx_full_s;
    rx_pop_s           = rx_rd_s && !rx_empty_s;
    rx_underflow_set_s = rx_rd_s && rx_empty_s;
  end

  // Next TX occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    tx_count_next_s = tx_count_r;
    case ({tx_push_s, tx_pop_s})
      2'b10:   tx_count_next_s = tx_count_r + cnt_one_c;
      2'b01:   tx_count_next_s = tx_count_r - cnt_one_c;
      default: tx_count_next_s = tx_count_r;
    endcase
  end

  // Next RX occupancy: simultaneous stream push and CPU pop leave the count unchanged.
  always_comb begin
    rx_count_next_s = rx_count_r;
    case ({rx_push_s, rx_pop_s})
      2'b10:   rx_count_next_s = rx_count_r + cnt_one_c;
      2'b01:   rx_count_next_s = rx_count_r - cnt_one_c;
      default: rx_count_next_s = rx_count_r;
    endcase
  end

  // CPU read mux; unmapped or write-only addresses read as zero.
  always_comb begin
    rd_data_s = data_zero_c;
    if (rx_rd_s) begin
      if (rx_empty_s) begin
        rd_data_s = data_zero_c;
      end else begin
        rd_data_s = rx_mem[rx_rd_ptr_r];
      end
    end else if (status_rd_s) begin
      rd_data_s = data_width'(status_s);
    end else if (ctrl_rd_s) begin
      rd_data_s = data_width'(rx_count_r);
    end else begin
      rd_data_s = data_zero_c;
    end
  end

  // TX pointers and count; a flush overrides any same-cycle push or pop.
  always_ff @(posedge clk_i) begin
    if (reset_i || tx_flush_s) begin
      tx_wr_ptr_r <= ptr_zero_c;
      tx_rd_ptr_r <= ptr_zero_c;
      tx_count_r  <= cnt_zero_c;
    end else begin
      if (tx_push_s) begin
        tx_wr_ptr_r <= tx_wr_ptr_r + ptr_one_c;
      end
      if (tx_pop_s) begin
        tx_rd_ptr_r <= tx_rd_ptr_r + ptr_one_c;
      end
      tx_count_r <= tx_count_next_s;
    end
  end

  // TX storage write for accepted CPU bytes.
  always_ff @(posedge clk_i) begin
    if (!reset_i && !tx_flush_s && tx_push_s) begin
      tx_mem[tx_wr_ptr_r] <= data_i;
    end
  end

  // RX pointers and count; a flush overrides any same-cycle push or pop.
  always_ff @(posedge clk_i) begin
    if (reset_i || rx_flush_s) begin
      rx_wr_ptr_r <= ptr_zero_c;
      rx_rd_ptr_r <= ptr_zero_c;
      rx_count_r  <= cnt_zero_c;
    end else begin
      if (rx_push_s) begin
        rx_wr_ptr_r <= rx_wr_ptr_r + ptr_one_c;
      end
      if (rx_pop_s) begin
        rx_rd_ptr_r <= rx_rd_ptr_r + ptr_one_c;
      end
      rx_count_r <= rx_count_next_s;
    end
  end

  // RX storage write for accepted stream bytes.
  always_ff @(posedge clk_i) begin
    if (!reset_i && !rx_flush_s && rx_push_s) begin
      rx_mem[rx_wr_ptr_r] <= rx_data_i;
    end
  end

  // Sticky error flags; a clear wins over a same-cycle set.
  always_ff @(posedge clk_i) begin
    if (reset_i || flag_clear_s) begin
      tx_overflow_r  <= 1'b0;
      rx_underflow_r <= 1'b0;
    end else begin
      if (tx_overflow_set_s) begin
        tx_overflow_r <= 1'b1;
      end
      if (rx_underflow_set_s) begin
        rx_underflow_r <= 1'b1;
      end
    end
  end

  // Registered CPU read data: updates on every read edge, holds during writes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_r <= data_zero_c;
    end else if (!rd_wr_i) begin
      data_r <= rd_data_s;
    end
  end

endmodule

// File: tb/tb_fifo_stream_bridge_6502.sv
// Testbench for fifo_stream_bridge_6502: a queue-based reference model computes
// expected CPU read data and TX stream bytes; a monitor compares them against
// the DUT whenever it presents output.
module tb_fifo_stream_bridge_6502;

  localparam int          FSIZE = 2;
  localparam int          DEPTH = 1 << FSIZE;
  localparam logic [15:0] BASE  = 16'hC010;
  localparam logic [15:0] IDLE_ADDR = 16'hC014;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        rd_wr;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  // Scoreboard queues and expected handshake levels
  logic [7:0] rd_q[$];
  logic [7:0] exp_tx[$];
  logic       exp_tx_valid = 1'b0;
  logic       exp_rx_ready = 1'b0;

  always #5 clk = ~clk;

  fifo_stream_bridge_6502 #(
    .BaseAddress  (int'(BASE)),
    .FIFOSize     (FSIZE),
    .address_width(16),
    .data_width   (8)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .address_i (address),
    .data_i    (data_in),
    .data_o    (data_out),
    .rd_wr_i   (rd_wr),
    .tx_data_o (tx_data),
    .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready),
    .rx_data_i (rx_data),
    .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready)
  );

  // Drive one cycle of stimulus and advance the reference model across the coming edge.
  task automatic cycle(input logic rst, input logic [15:0] addr, input logic rw,
                       input logic [7:0] din, input logic txr, input logic rxv,
                       input logic [7:0] rxd);
    int txn;
    int rxn;
    logic [7:0]  rv;
    logic [15:0] off;
    logic fl_tx, fl_rx, clr;
    @(posedge clk);
    #1;
    reset = rst; address = addr; rd_wr = rw; data_in = din;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    txn = m_tx.size();
    rxn = m_rx.size();
    exp_tx_valid = !rst && (txn > 0);
    exp_rx_ready = !rst && (rxn < DEPTH);
    if (rst) begin
      m_tx.delete(); m_rx.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      off = addr - BASE;
      if (!rw) begin
        case (off)
          16'd1:   rv = (rxn > 0) ? m_rx[0] : 8'h00;
          16'd2:   rv = {2'b00, m_unf, m_ovf, rxn == 0, rxn == DEPTH, txn == 0, txn == DEPTH};
          16'd3:   rv = 8'(rxn);
          default: rv = 8'h00;
        endcase
        rd_q.push_back(rv);
      end
      fl_tx = rw && (off == 16'd3) && din[1];
      fl_rx = rw && (off == 16'd3) && din[2];
      clr   = rw && (off == 16'd3) && din[0];
      if (fl_tx) begin
        m_tx.delete();
      end else begin
        if (txn > 0 && txr) exp_tx.push_back(m_tx.pop_front());
        if (rw && off == 16'd0) begin
          if (txn < DEPTH) m_tx.push_back(din);
          else if (!clr) m_ovf = 1'b1;
        end
      end
      if (fl_rx) begin
        m_rx.delete();
      end else begin
        if (!rw && off == 16'd1) begin
          if (rxn > 0) void'(m_rx.pop_front());
          else if (!clr) m_unf = 1'b1;
        end
        if (rxv && rxn < DEPTH) m_rx.push_back(rxd);
      end
      if (clr) begin
        m_ovf = 1'b0; m_unf = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n, input logic txr);
    for (int i = 0; i < n; i++) cycle(1'b0, IDLE_ADDR, 1'b1, 8'($urandom), txr, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic [15:0] off, input logic [7:0] d, input logic txr);
    cycle(1'b0, BASE + off, 1'b1, d, txr, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [15:0] off, input logic txr);
    cycle(1'b0, BASE + off, 1'b0, 8'h00, txr, 1'b0, 8'h00);
  endtask

  // Monitor: compare read data, handshake levels and TX stream bytes mid-cycle.
  logic       started = 1'b0;
  logic       prev_rst = 1'b0;
  logic       prev_read = 1'b0;
  logic [7:0] last_rd = 8'h00;
  always @(negedge clk) begin
    logic [7:0] e;
    logic discard;
    if (started) begin
      checks++;
      if (prev_rst) begin
        last_rd = 8'h00;
        if (data_out !== 8'h00) begin
          errors++; $display("FAIL data_reset got %h exp 00", data_out);
        end
      end else if (prev_read) begin
        if (rd_q.size() == 0) begin
          errors++; $display("FAIL read_unexpected got %h exp none", data_out);
        end else begin
          e = rd_q.pop_front();
          last_rd = e;
          if (data_out !== e) begin
            errors++; $display("FAIL read_data got %h exp %h at %0t", data_out, e, $time);
          end
        end
      end else if (data_out !== last_rd) begin
        errors++; $display("FAIL data_hold got %h exp %h at %0t", data_out, last_rd, $time);
      end
    end
    checks++;
    if (tx_valid !== exp_tx_valid) begin
      errors++; $display("FAIL tx_valid got %b exp %b at %0t", tx_valid, exp_tx_valid, $time);
    end
    checks++;
    if (rx_ready !== exp_rx_ready) begin
      errors++; $display("FAIL rx_ready got %b exp %b at %0t", rx_ready, exp_rx_ready, $time);
    end
    discard = reset || (rd_wr && address == BASE + 16'd3 && data_in[1]);
    if (tx_valid === 1'b1 && tx_ready && !discard) begin
      checks++;
      if (exp_tx.size() == 0) begin
        errors++; $display("FAIL tx_unexpected got %h exp none at %0t", tx_data, $time);
      end else begin
        e = exp_tx.pop_front();
        if (tx_data !== e) begin
          errors++; $display("FAIL tx_data got %h exp %h at %0t", tx_data, e, $time);
        end
      end
    end
    prev_rst  = reset;
    prev_read = !rd_wr;
    if (reset) started = 1'b1;
  end

  initial begin
    reset = 1'b1; address = IDLE_ADDR; rd_wr = 1'b1; data_in = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    cycle(1'b1, IDLE_ADDR, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, IDLE_ADDR, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    idle(1, 1'b0);
    rd(16'd2, 1'b0);                       // status after reset
    // Three bytes queued, then released back-to-back
    wr(16'd0, 8'h11, 1'b0); wr(16'd0, 8'h22, 1'b0); wr(16'd0, 8'h33, 1'b0);
    idle(5, 1'b1);
    // Overflow: five writes into a four-deep FIFO
    for (int i = 0; i < 5; i++) wr(16'd0, 8'h50 + 8'(i), 1'b0);
    rd(16'd2, 1'b0);
    wr(16'd0, 8'h99, 1'b1);                // write while full and draining: dropped
    idle(6, 1'b1);
    rd(16'd2, 1'b0);
    wr(16'd3, 8'h01, 1'b0);
    rd(16'd2, 1'b0);
    // RX fill to back-pressure, occupancy read, then drain
    for (int i = 0; i < 6; i++) cycle(1'b0, IDLE_ADDR, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA0 + 8'(i < 4 ? i : 0));
    rd(16'd3, 1'b0);
    for (int i = 0; i < 4; i++) rd(16'd1, 1'b0);
    // Underflow and status
    rd(16'd1, 1'b0);
    rd(16'd2, 1'b0);
    // Simultaneous stream push and CPU pop at occupancy 2
    cycle(1'b0, IDLE_ADDR, 1'b1, 8'h00, 1'b0, 1'b1, 8'hB0);
    cycle(1'b0, IDLE_ADDR, 1'b1, 8'h00, 1'b0, 1'b1, 8'hB1);
    for (int i = 0; i < 3; i++) cycle(1'b0, BASE + 16'd1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hB2 + 8'(i));
    rd(16'd3, 1'b0);
    wr(16'd3, 8'h05, 1'b0);                // clear flags and flush RX
    rd(16'd2, 1'b0);
    // Reset during a TX drain
    wr(16'd0, 8'hC1, 1'b0); wr(16'd0, 8'hC2, 1'b0); wr(16'd0, 8'hC3, 1'b0);
    idle(1, 1'b1);
    cycle(1'b1, IDLE_ADDR, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00);
    idle(3, 1'b1);
    rd(16'd2, 1'b1);
    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [15:0] a;
      logic rw;
      logic [7:0] d;
      r = $urandom_range(0, 99);
      d = 8'($urandom);
      rw = 1'b1;
      a = IDLE_ADDR;
      if (r < 28) a = BASE;
      else if (r < 46) begin a = BASE + 16'd1; rw = 1'b0; end
      else if (r < 54) begin a = BASE + 16'd2; rw = 1'b0; end
      else if (r < 60) begin a = BASE + 16'd3; rw = 1'b0; end
      else if (r < 62) begin a = BASE + 16'd3; d = 8'($urandom_range(0, 7)); end
      else if (r < 66) begin a = ($urandom_range(0, 1) == 0) ? BASE : IDLE_ADDR; rw = 1'b0; end
      else if (r < 70) a = BASE + 16'($urandom_range(1, 2));
      else if (r < 74) a = BASE ^ 16'h8003;
      else a = IDLE_ADDR;
      cycle(($urandom_range(0, 299) == 0), a, rw, d, 1'($urandom), 1'($urandom), 8'($urandom));
    end
    idle(12, 1'b1);
    checks++;
    if (exp_tx.size() != 0) begin
      errors++; $display("FAIL tx_missing got %0d pending exp 0", exp_tx.size());
    end
    checks++;
    if (rd_q.size() != 0) begin
      errors++; $display("FAIL read_missing got %0d pending exp 0", rd_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_stream_bridge_6502.md
Name: fifo_stream_bridge_6502

Overview:
- Memory-mapped bridge between the 6502 bus and a pair of valid/ready byte streams.
- CPU writes are queued in a TX FIFO and drained by a stream consumer.
- A stream producer fills an RX FIFO that the CPU pops.
- Sits on the CPU bus beside the other peripherals. Gives firmware a buffered path to and from streaming hardware blocks (UART cores, packet engines).

Parameters:
- BaseAddress, 0, first of four consecutive register addresses.
- FIFOSize, 4, log2 of the depth of each FIFO (depth = 2**FIFOSize, both FIFOs).
- address_width, 16, CPU address bus width.
- data_width, 8, CPU data bus and stream data width; must be >= 8.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- address_i  in  address_width  CPU address.
- data_i  in  data_width  CPU write data.
- data_o  out  data_width  CPU read data, registered.
- rd_wr_i  in  1  1 = write, 0 = read.
- tx_data_o  out  data_width  TX stream data (TX FIFO head).
- tx_valid_o  out  1  TX stream valid.
- tx_ready_i  in  1  TX stream ready from consumer.
- rx_data_i  in  data_width  RX stream data.
- rx_valid_i  in  1  RX stream valid.
- rx_ready_o  out  1  RX stream ready.

Behaviour:
- Register map (offsets from BaseAddress):
  - +0 TxData, W: push data_i into TX FIFO.
  - +1 RxData, R: return RX head and pop.
  - +2 Status, R: bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 tx_overflow, bit5 rx_underflow; bits 6 and up read 0.
  - +3 Control: W bit0 clear sticky flags, bit1 flush TX, bit2 flush RX. R returns RX occupancy, zero-extended.
  - Any other address: reads return 0, writes are ignored.
- Bus timing:
  - An access is any clock edge with the matching address and rd_wr_i value.
  - The address is held for exactly one cycle per access.
  - data_o updates on the edge of a read access (1-cycle latency) and holds its value while rd_wr_i = 1.
- FIFO structure:
  - Each FIFO is a synchronous circular buffer with wrapping read/write pointers and a FIFOSize+1 bit occupancy count.
  - full means count == depth; empty means count == 0.
  - All full/empty decisions use the pre-edge state.
- TxData write:
  - If TX is not full: store and increment the write pointer.
  - If TX is full: drop the data and set tx_overflow (sticky). A pop in the same cycle does not rescue it.
- TX stream:
  - tx_valid_o = !tx_empty; tx_data_o = head (show-ahead).
  - Pop when tx_valid_o && tx_ready_i.
  - Push and pop on the same edge leave count unchanged; both pointers advance.
- RxData read:
  - If RX is not empty: data_o <= head, pop.
  - If RX is empty: data_o <= 0, set rx_underflow (sticky), no pointer change.
- RX stream:
  - rx_ready_o = !rx_full.
  - Accept rx_data_i when rx_valid_i && rx_ready_o.
  - A stream push and CPU pop on the same edge leave count unchanged.
  - Data is never dropped on RX; back-pressure only.
- Control write:
  - Flush sets both pointers and count of that FIFO to 0 on the edge.
  - A flush has priority over a same-cycle push or pop to that FIFO. Discarded traffic sets no flags, and no stream handshake completes that cycle (tx_valid_o / rx_ready_o still follow pre-edge state; the transfer is discarded).
  - Clear has priority over a same-cycle flag set.
  - Bits may be combined in one write.
- Reset (reset_i = 1 at an edge):
  - Pointers, counts, sticky flags and data_o go to 0.
  - While reset_i is high, tx_valid_o = 0 and rx_ready_o = 0.
  - After release: tx_valid_o = 0 and rx_ready_o = 1.
  - Reset mid-stream discards all buffered data.
- FIFO storage contents need no reset.

Test Plan:
- Reset, then read Status -> data_o = 0x0A (tx_empty, rx_empty). tx_valid_o = 0, rx_ready_o = 1.
- tx_ready_i = 0; write 0x11, 0x22, 0x33 to TxData; raise tx_ready_i -> stream emits 0x11, 0x22, 0x33 on consecutive cycles, then tx_valid_o = 0.
- FIFOSize = 2: with tx_ready_i = 0, write 5 bytes -> Status bit0 = 1 and bit4 = 1; stream drains first 4 only. Control write 0x01 -> bit4 clears.
- Drive rx_valid_i with 0xA0..0xA3 (FIFOSize = 2) -> rx_ready_o falls after 4th accept; Control read = 4. Four RxData reads return 0xA0..0xA3; rx_ready_o rises after first pop.
- RxData read while empty -> data_o = 0, Status bit5 = 1. Simultaneous stream push and CPU pop at count 2 -> count stays 2, data order preserved.
- Fill TX with 3 bytes, assert reset_i for one cycle mid-drain -> tx_valid_o = 0, Status = 0x0A, no further stream output.
